// File: rtl/retinex_stretch.sv
// ---------------------------------------------------------------------------
// retinex_stretch
//
// Per-frame linear contrast stretch that sits in front of the gamma LUT of
// the Retinex chain. The wide unsigned Retinex output is mapped onto 0..255
// using min/max statistics gathered over one frame and applied to the next,
// so no frame buffer is needed. The scale factor
//     q = floor(255 * 2^FRAC / (max - min))
// is produced by a restoring divider that runs during blanking. The pixel
// path is a fixed 3-stage pipeline with no backpressure.
//
// Ports:
//   clk            clock
//   rst            synchronous, active-high reset
//   src_valid      input pixel qualifier
//   src_data       input pixel, DW_IN bits unsigned
//   src_frame_end  one-cycle pulse on the last cycle of a frame
//   dst_valid      output qualifier (3 cycles after src_valid)
//   dst_data       stretched 8-bit pixel
//   coef_busy      high while a new coefficient pair is being computed/loaded
// ---------------------------------------------------------------------------
module retinex_stretch #(
    parameter int DW_IN = 12,
    parameter int FRAC  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             src_valid,
    input  logic [DW_IN-1:0] src_data,
    input  logic             src_frame_end,
    output logic             dst_valid,
    output logic [7:0]       dst_data,
    output logic             coef_busy
);

    localparam int QW = 8 + FRAC;
    localparam int PW = DW_IN + QW;
    localparam int CW = $clog2(QW);

    // 255 * 2^FRAC doubles as the divider's dividend and as the scale used
    // for a flat frame (range of zero).
    localparam logic [QW-1:0] Q_MAX     = {8'd255, {FRAC{1'b0}}};
    localparam logic [QW-1:0] SCALE_RST =
        QW'((64'd255 << FRAC) / ((64'd1 << DW_IN) - 64'd1));
    localparam logic [PW:0]   ROUND_ADD = (PW+1)'(1) << (FRAC - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        LOAD = 2'd2
    } state_t;

    // Statistics tracker
    logic [DW_IN-1:0] cur_min_q, cur_min_d;
    logic [DW_IN-1:0] cur_max_q, cur_max_d;
    logic             have_q, have_d;
    logic [DW_IN-1:0] frm_min, frm_max;
    logic             frm_has;

    // Coefficient engine
    state_t           state_q, state_d;
    logic [DW_IN-1:0] lat_min_q, lat_min_d;
    logic [DW_IN-1:0] den_q, den_d;
    logic [DW_IN-1:0] rem_q, rem_d;
    logic [QW-1:0]    quo_q, quo_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             zero_q, zero_d;
    logic [DW_IN-1:0] min_app_q, min_app_d;
    logic [QW-1:0]    scale_app_q, scale_app_d;
    logic [DW_IN:0]   trial;
    logic [DW_IN:0]   trial_diff;

    // Pixel pipeline
    logic             v1_q, v1_d;
    logic [DW_IN-1:0] d1_q, d1_d;
    logic [QW-1:0]    sc1_q, sc1_d;
    logic             v2_q, v2_d;
    logic [PW-1:0]    p2_q, p2_d;
    logic             dst_valid_q, dst_valid_d;
    logic [7:0]       dst_data_q, dst_data_d;
    logic [PW:0]      rnd;
    logic [PW:0]      r3;

    // Frame statistics including the pixel of the current cycle, so a pixel
    // that coincides with frame_end is counted in the ending frame. The
    // first valid pixel of a frame loads both extremes directly.
    always_comb begin
        frm_min = cur_min_q;
        frm_max = cur_max_q;
        frm_has = have_q;
        if (src_valid) begin
            frm_has = 1'b1;
            if (!have_q) begin
                frm_min = src_data;
                frm_max = src_data;
            end else begin
                if (src_data < cur_min_q) frm_min = src_data;
                if (src_data > cur_max_q) frm_max = src_data;
            end
        end
        cur_min_d = frm_min;
        cur_max_d = frm_max;
        have_d    = frm_has;
        if (src_frame_end) begin
            have_d = 1'b0;
        end
    end

    // Coefficient FSM. The quotient register starts out holding the
    // dividend and receives one quotient bit per cycle at its LSB while the
    // dividend bits leave at its MSB. For a flat frame it already holds the
    // wanted scale, so DIV just passes through for a single cycle.
    // Frame ends that arrive outside IDLE are ignored here; the tracker is
    // re-armed regardless.
    always_comb begin
        state_d     = state_q;
        lat_min_d   = lat_min_q;
        den_d       = den_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        cnt_d       = cnt_q;
        zero_d      = zero_q;
        min_app_d   = min_app_q;
        scale_app_d = scale_app_q;
        trial       = {rem_q, quo_q[QW-1]};
        trial_diff  = trial - {1'b0, den_q};
        case (state_q)
            IDLE: begin
                if (src_frame_end && frm_has) begin
                    lat_min_d = frm_min;
                    den_d     = frm_max - frm_min;
                    zero_d    = (frm_max == frm_min);
                    rem_d     = '0;
                    quo_d     = Q_MAX;
                    cnt_d     = '0;
                    state_d   = DIV;
                end
            end
            DIV: begin
                if (zero_q) begin
                    state_d = LOAD;
                end else begin
                    if (trial >= {1'b0, den_q}) begin
                        rem_d = trial_diff[DW_IN-1:0];
                        quo_d = {quo_q[QW-2:0], 1'b1};
                    end else begin
                        rem_d = trial[DW_IN-1:0];
                        quo_d = {quo_q[QW-2:0], 1'b0};
                    end
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CW'(QW - 1)) begin
                        state_d = LOAD;
                    end
                end
            end
            LOAD: begin
                min_app_d   = lat_min_q;
                scale_app_d = quo_q;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Pixel path. The scale is captured next to the offset pixel in S1 so
    // every pixel sees one coherent (min, scale) pair even when LOAD lands
    // while it is in flight. S3 rounds to nearest and saturates at 255.
    always_comb begin
        v1_d  = src_valid;
        d1_d  = (src_data > min_app_q) ? (src_data - min_app_q) : '0;
        sc1_d = scale_app_q;

        v2_d  = v1_q;
        p2_d  = PW'(d1_q) * PW'(sc1_q);

        rnd         = {1'b0, p2_q} + ROUND_ADD;
        r3          = rnd >> FRAC;
        dst_valid_d = v2_q;
        dst_data_d  = (|r3[PW:8]) ? 8'd255 : r3[7:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_min_q   <= '0;
            cur_max_q   <= '0;
            have_q      <= 1'b0;
            state_q     <= IDLE;
            lat_min_q   <= '0;
            den_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            cnt_q       <= '0;
            zero_q      <= 1'b0;
            min_app_q   <= '0;
            scale_app_q <= SCALE_RST;
            v1_q        <= 1'b0;
            d1_q        <= '0;
            sc1_q       <= '0;
            v2_q        <= 1'b0;
            p2_q        <= '0;
            dst_valid_q <= 1'b0;
            dst_data_q  <= '0;
        end else begin
            cur_min_q   <= cur_min_d;
            cur_max_q   <= cur_max_d;
            have_q      <= have_d;
            state_q     <= state_d;
            lat_min_q   <= lat_min_d;
            den_q       <= den_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            cnt_q       <= cnt_d;
            zero_q      <= zero_d;
            min_app_q   <= min_app_d;
            scale_app_q <= scale_app_d;
            v1_q        <= v1_d;
            d1_q        <= d1_d;
            sc1_q       <= sc1_d;
            v2_q        <= v2_d;
            p2_q        <= p2_d;
            dst_valid_q <= dst_valid_d;
            dst_data_q  <= dst_data_d;
        end
    end

    assign dst_valid = dst_valid_q;
    assign dst_data  = dst_data_q;
    assign coef_busy = (state_q != IDLE);

endmodule

// File: tb/tb_retinex_stretch.sv
// ---------------------------------------------------------------------------
// tb_retinex_stretch
//
// Directed bench for retinex_stretch with default parameters (DW_IN=12,
// FRAC=16). Each step drives one cycle of input together with the
// hand-computed output that pixel must produce three cycles later and,
// optionally, the coef_busy value expected in the step's own cycle.
// ---------------------------------------------------------------------------
module tb_retinex_stretch;

    logic        clk;
    logic        rst;
    logic        src_valid;
    logic [11:0] src_data;
    logic        src_frame_end;
    logic        dst_valid;
    logic [7:0]  dst_data;
    logic        coef_busy;

    int total;
    int bad;
    int step;

    // Expected-output slots for the three pixels in flight, slot 2 oldest.
    logic       exp_en [0:2];
    logic       exp_v  [0:2];
    logic [7:0] exp_d  [0:2];

    retinex_stretch #(.DW_IN(12), .FRAC(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .src_valid     (src_valid),
        .src_data      (src_data),
        .src_frame_end (src_frame_end),
        .dst_valid     (dst_valid),
        .dst_data      (dst_data),
        .coef_busy     (coef_busy)
    );

    // 10-time-unit clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare the DUT output against the expectation of the pixel that
    // entered three cycles ago.
    task automatic checkOutput();
        if (exp_en[2]) begin
            total++;
            assert (dst_valid === exp_v[2]) else begin
                bad++;
                $error("[TB] FAIL dst_valid step=%0d obs=%0b exp=%0b", step, dst_valid, exp_v[2]);
            end
            if (exp_v[2]) begin
                total++;
                assert (dst_data === exp_d[2]) else begin
                    bad++;
                    $error("[TB] FAIL dst_data step=%0d obs=%0d exp=%0d", step, dst_data, exp_d[2]);
                end
            end
        end
    endtask

    // Drive one cycle. eb < 0 skips the coef_busy check for this cycle.
    task automatic applyStimulus(input logic v, input logic [11:0] d, input logic fe,
                                 input logic ev, input logic [7:0] ed, input int eb);
        src_valid     = v;
        src_data      = d;
        src_frame_end = fe;
        @(negedge clk);
        if (eb >= 0) begin
            total++;
            assert (coef_busy === eb[0]) else begin
                bad++;
                $error("[TB] FAIL coef_busy step=%0d obs=%0b exp=%0b", step, coef_busy, eb[0]);
            end
        end
        checkOutput();
        exp_en[2] = exp_en[1]; exp_v[2] = exp_v[1]; exp_d[2] = exp_d[1];
        exp_en[1] = exp_en[0]; exp_v[1] = exp_v[0]; exp_d[1] = exp_d[0];
        exp_en[0] = 1'b1;      exp_v[0] = ev;       exp_d[0] = ed;
        step++;
        @(posedge clk);
        #1;
    endtask

    // Hold reset for one active edge, check the cleared outputs, release.
    task automatic applyReset();
        src_valid     = 1'b0;
        src_data      = '0;
        src_frame_end = 1'b0;
        rst           = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        total++;
        assert (dst_valid === 1'b0) else begin
            bad++;
            $error("[TB] FAIL rst_dst_valid obs=%0b exp=0", dst_valid);
        end
        total++;
        assert (dst_data === 8'd0) else begin
            bad++;
            $error("[TB] FAIL rst_dst_data obs=%0d exp=0", dst_data);
        end
        total++;
        assert (coef_busy === 1'b0) else begin
            bad++;
            $error("[TB] FAIL rst_coef_busy obs=%0b exp=0", coef_busy);
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            exp_en[i] = 1'b1;
            exp_v[i]  = 1'b0;
            exp_d[i]  = 8'd0;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        total         = 0;
        bad           = 0;
        step          = 0;
        rst           = 1'b1;
        src_valid     = 1'b0;
        src_data      = '0;
        src_frame_end = 1'b0;
        for (int i = 0; i < 3; i++) begin
            exp_en[i] = 1'b0;
            exp_v[i]  = 1'b0;
            exp_d[i]  = 8'd0;
        end

        applyReset();

        // Reset coefficients (min 0, scale 4080); frame end on the last pixel
        applyStimulus(1, 12'd0,    0, 1, 8'd0,   0);
        applyStimulus(1, 12'd2048, 0, 1, 8'd128, 0);
        applyStimulus(1, 12'd4095, 1, 1, 8'd255, 0);
        for (int i = 1; i <= 25; i++) applyStimulus(0, 12'd0, 0, 0, 8'd0, 1);
        applyStimulus(0, 12'd0, 0, 0, 8'd0, 0);

        // Frame A spans 100..1100, still using scale 4080
        applyStimulus(1, 12'd100,  0, 1, 8'd6,  0);
        applyStimulus(1, 12'd1100, 0, 1, 8'd68, 0);
        applyStimulus(1, 12'd600,  1, 1, 8'd37, 0);
        // Continuous stream across the LOAD boundary: old up to F+25
        for (int i = 1; i <= 25; i++) applyStimulus(1, 12'd600, 0, 1, 8'd37, 1);
        applyStimulus(1, 12'd600, 0, 1, 8'd127, 0);

        // Frame B with frame A coefficients (min 100, scale 16711)
        applyStimulus(1, 12'd100,  0, 1, 8'd0,   0);
        applyStimulus(1, 12'd600,  0, 1, 8'd127, 0);
        applyStimulus(1, 12'd1100, 0, 1, 8'd255, 0);
        applyStimulus(1, 12'd50,   0, 1, 8'd0,   0);
        applyStimulus(1, 12'd2000, 1, 1, 8'd255, 0);

        // Discarded frame: ends 10 cycles into the division
        for (int i = 1; i <= 10; i++) begin
            if (i % 2 == 1) applyStimulus(1, 12'd0,    (i == 10), 1, 8'd0,   1);
            else            applyStimulus(1, 12'd4095, (i == 10), 1, 8'd255, 1);
        end
        // Frame C starts while the divider is still busy
        applyStimulus(1, 12'd200, 0, 1, 8'd25, 1);
        for (int i = 12; i <= 25; i++) applyStimulus(0, 12'd0, 0, 0, 8'd0, 1);
        // Frame B coefficients (min 50, scale 8570)
        applyStimulus(1, 12'd1000, 0, 1, 8'd124, 0);
        applyStimulus(1, 12'd400,  1, 1, 8'd46,  0);

        // Frame C coefficients (min 200, scale 20889); flat frame of one 700
        for (int i = 1; i <= 25; i++) applyStimulus(0, 12'd0, 0, 0, 8'd0, 1);
        applyStimulus(1, 12'd700, 1, 1, 8'd159, 0);

        // Flat frame: one DIV cycle, LOAD, new coefficients from F+3
        applyStimulus(0, 12'd0,    0, 0, 8'd0,   1);
        applyStimulus(1, 12'd1000, 0, 1, 8'd255, 1);
        applyStimulus(1, 12'd700,  0, 1, 8'd0,   0);
        applyStimulus(1, 12'd701,  0, 1, 8'd255, 0);
        applyStimulus(1, 12'd650,  0, 1, 8'd0,   0);

        // Frame end without a pixel; frame holds 650..1000 so DIV starts
        applyStimulus(0, 12'd0, 1, 0, 8'd0, 0);
        for (int i = 1; i <= 8; i++) applyStimulus(0, 12'd0, 0, 0, 8'd0, 1);
        for (int i = 9; i <= 11; i++) applyStimulus(1, 12'd2048, 0, 1, 8'd255, 1);
        // Reset at F+12 aborts the division
        applyReset();

        // Empty frame: no division
        applyStimulus(0, 12'd0, 1, 0, 8'd0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 12'd0, 0, 0, 8'd0, 0);

        // Reset coefficients are back
        applyStimulus(1, 12'd2048, 0, 1, 8'd128, 0);
        applyStimulus(1, 12'd0,    0, 1, 8'd0,   0);
        applyStimulus(1, 12'd4095, 0, 1, 8'd255, 0);
        for (int i = 0; i < 4; i++) applyStimulus(0, 12'd0, 0, 0, 8'd0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
